// File: rtl/if_pkg.sv
// if_pkg: shared widths, reset constants and fetch-state encoding for the IF stage
package if_pkg;
  localparam int INSTR_W = 32;
  localparam int ADDR_W = 32;
  localparam logic [ADDR_W-1:0] RESET_PC = 32'h00000000;
  localparam logic [INSTR_W-1:0] NOP_INSTR = 32'h00000000;
  localparam logic [ADDR_W-1:0] PC_INC = 32'd4;
  typedef enum logic {BUBBLE = 1'b0, RUN = 1'b1} fetch_state_e;
endpackage

// File: rtl/if_fetch_unit_pc_reg.sv
// pc_reg: address-wide register with synchronous reset value and load enable
module pc_reg
  import if_pkg::*;
#(
  parameter logic [ADDR_W-1:0] RST_VAL = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ld,
  input  logic [ADDR_W-1:0] d,
  output logic [ADDR_W-1:0] q
);
  always_ff @(posedge clk)
    if (rst) q <= RST_VAL;
    else if (ld) q <= d;
endmodule

// File: rtl/if_fetch_unit.sv
// if_fetch_unit: PC, IF/ID register, stall and branch flush; PERF_CNT_EN adds fetch/stall counters
module if_fetch_unit
  import if_pkg::*;
#(
  parameter logic [ADDR_W-1:0]  RESET_PC  = if_pkg::RESET_PC,
  parameter logic [INSTR_W-1:0] NOP_INSTR = if_pkg::NOP_INSTR
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               Freeze,
  input  logic               BranchTaken,
  input  logic [ADDR_W-1:0]  BranchAddr,
  input  logic [INSTR_W-1:0] Instruction,
  output logic [ADDR_W-1:0]  PC,
  output logic [ADDR_W-1:0]  IfIdPC,
  output logic [INSTR_W-1:0] IfIdInstr,
  output logic               IfIdValid
`ifdef PERF_CNT_EN
  ,
  output logic [31:0]        FetchCount,
  output logic [31:0]        StallCount
`endif
);
  logic [ADDR_W-1:0] pc_inc, pc_nxt;
  logic fetch, stall;
  fetch_state_e state, state_nxt;
  assign pc_inc = PC + PC_INC;
  assign fetch = !BranchTaken && !Freeze;
  assign stall = Freeze && !BranchTaken;
  // Masking the target keeps PC word-aligned without a separate alignment check
  assign pc_nxt = BranchTaken ? (BranchAddr & ~ADDR_W'(3)) : pc_inc;
  pc_reg #(.RST_VAL(RESET_PC)) u_pc (
    .clk(clk),
    .rst(rst),
    .ld (!stall),
    .d  (pc_nxt),
    .q  (PC)
  );
  always_ff @(posedge clk)
    if (rst) state <= BUBBLE;
    else state <= state_nxt;
  always_comb begin
    state_nxt = state;
    state_nxt = BranchTaken ? BUBBLE : (Freeze ? state : RUN);
  end
  assign IfIdValid = (state == RUN);
  always_ff @(posedge clk)
    if (rst || BranchTaken) begin
      IfIdPC    <= '0;
      IfIdInstr <= NOP_INSTR;
    end else if (!Freeze) begin
      IfIdPC    <= pc_inc;
      IfIdInstr <= Instruction;
    end
`ifdef PERF_CNT_EN
  always_ff @(posedge clk)
    if (rst) begin
      FetchCount <= '0;
      StallCount <= '0;
    end else begin
      if (fetch && FetchCount != '1) FetchCount <= FetchCount + 32'd1;
      if (stall && StallCount != '1) StallCount <= StallCount + 32'd1;
    end
`else
  logic unused_fetch;
  assign unused_fetch = fetch;
`endif
endmodule
